mux_rr_arb: RTL and testbench
=============================

Name: mux_rr_arb

Overview:
- Parametrised successor to the team's 2:1 combinational mux.
- Selects one of N input channels, each WIDTH bits, onto a single registered output. Selection is made by an internal arbiter rather than an external select line.
- Every input channel and the output use valid/ready handshakes.
- Sits between multiple producer blocks and one shared consumer, such as a shared bus or a result writeback port.

Parameters:
- WIDTH, default 8: data width per channel, in bits; must be at least 1.
- N, default 4: number of input channels; must be at least 2.
- FIXED_PRIO, default 0: arbitration mode. 0 selects round-robin; 1 selects fixed priority, where the lowest index wins.
- SELW, default $clog2(N): width of the out_sel port. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-high.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.
- out_sel  out  SELW  registered index of the channel that supplied out_data.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. Reset mid-transfer discards the held beat. in_ready is 0 while out_valid would be 1; after reset it follows the rules below.
- Transfer definitions:
  - An input transfer on channel i occurs on a clock edge where in_valid[i] && in_ready[i].
  - An output transfer occurs on a clock edge where out_valid && out_ready.
- Load enable: load_en = !out_valid || out_ready, combinational. The register accepts a new beat when it is empty or being drained in the same cycle.
- Grant, combinational, one-hot or zero:
  - Round-robin: the first i with in_valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Fixed priority: the lowest i with in_valid[i]=1.
- in_ready[i] = load_en && grant[i]. At most one bit of in_ready is high. in_ready may depend on in_valid and out_ready.
- On an input transfer from channel g:
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - Round-robin mode: ptr <= (g+1) mod N, wrapping from N-1 to 0. Fixed-priority mode: ptr is unchanged.
- load_en=1 with no in_valid bit set: out_valid <= 0. out_data and out_sel hold their previous values, don't-care to the consumer.
- Stall (out_valid && !out_ready): out_data, out_sel and out_valid hold; all in_ready bits are 0.
- Simultaneous drain and load in one cycle: allowed. Throughput is one beat per cycle with no bubble.
- Latency: 1 cycle from input transfer to out_valid.
- No input beat is duplicated or dropped.
- Fairness: in round-robin mode, with all channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0. No channel waits more than N-1 grants.
- ptr changes only on an input transfer; it never advances on idle cycles.
- in_data of a non-granted channel is ignored. Producers must hold in_data and in_valid stable until their own transfer.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately. After release, a single valid channel 2 with data 0xA5 gives out_data=0xA5 and out_sel=2 one cycle later.
- Round-robin sweep (N=4, WIDTH=8, FIXED_PRIO=0): all in_valid=4'b1111, in_data[i]=0x10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0 and out_data 0x10,0x11,0x12,0x13,0x10 on consecutive cycles.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_sel stable and in_ready=4'b0000 for those 3 cycles. On out_ready=1, the next granted beat appears the following cycle with no bubble.
- Sparse and wrap: ptr=3 with only in_valid[1] set -> grant to channel 1, then ptr=2. Next, with in_valid=4'b0011 -> channel 1 is not granted before channel 0 wraps; grant order is 0 then 1.
- Fixed priority (FIXED_PRIO=1): in_valid=4'b1110 held, out_ready=1 -> out_sel=1 every cycle. Channel 3 is starved by design.
- Scoreboard: random in_valid, in_data and out_ready for 2000 cycles -> every input transfer appears exactly once at the output in order, with the correct out_sel.

Source files
------------

// File: rtl/mux_rr_arb.sv
// N-channel valid/ready multiplexer with a single registered output stage.
// The channel is chosen by a round-robin or fixed-priority arbiter.
module mux_rr_arb #(
    parameter int WIDTH      = 8,
    parameter int N          = 4,
    parameter int FIXED_PRIO = 0,
    parameter int SELW       = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_sel
);

    logic            load_en;
    logic [N-1:0]    grant;
    logic [SELW-1:0] grant_idx;
    logic            grant_any;
    logic [SELW-1:0] ptr;

    assign load_en  = !out_valid || out_ready;
    assign in_ready = load_en ? grant : '0;

    // Scan order starts at ptr and wraps; fixed priority simply starts at 0.
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (FIXED_PRIO != 0) begin
                idx = k;
            end else begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end
            if (!grant_any && in_valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SELW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_sel   <= grant_idx;
                if (FIXED_PRIO == 0) begin
                    ptr <= (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Randomised and directed bench for mux_rr_arb; drives a round-robin and a
// fixed-priority instance from the same inputs against a behavioural model.
module tb_mux_rr_arb;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic           out_ready = 1'b1;

    logic [N-1:0]   rdy [2];
    logic [W-1:0]   od  [2];
    logic           ov  [2];
    logic [1:0]     os  [2];

    int errors = 0;
    int checks = 0;

    // Behavioural state per instance: 0 = round-robin, 1 = fixed priority
    int mv [2];
    int md [2];
    int ms [2];
    int mp [2];
    int q0 [$];
    int q1 [$];

    always #5 clk = ~clk;

    mux_rr_arb #(.WIDTH(W), .N(N), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .out_data(od[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_sel(os[0])
    );

    mux_rr_arb #(.WIDTH(W), .N(N), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .out_data(od[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_sel(os[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input int mode, input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mode != 0) ? k : (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; md[m] = 0; ms[m] = 0; mp[m] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One clock: check ready and drained beats before the edge, register state after it.
    task automatic step();
        int g;
        int b;
        logic [N-1:0] exp_rdy;
        #1;
        for (int m = 0; m < 2; m++) begin
            g = model_grant(m, mp[m], in_valid);
            exp_rdy = '0;
            if ((mv[m] == 0 || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
            check(m == 0 ? "rr_in_ready" : "fp_in_ready", 32'(rdy[m]), 32'(exp_rdy));
            if (ov[m] && out_ready) begin
                check("sb_nonempty", 32'((m == 0 ? q0.size() : q1.size()) != 0), 32'd1);
                if ((m == 0 ? q0.size() : q1.size()) != 0) begin
                    b = (m == 0) ? q0.pop_front() : q1.pop_front();
                    check(m == 0 ? "rr_sb_data" : "fp_sb_data", 32'(od[m]), 32'(b & 'hff));
                    check(m == 0 ? "rr_sb_sel" : "fp_sb_sel", 32'(os[m]), 32'(b >> 8));
                end
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (mv[m] == 0 || out_ready) begin
                g = model_grant(m, mp[m], in_valid);
                if (g >= 0) begin
                    mv[m] = 1;
                    md[m] = int'(in_data[g*W +: W]);
                    ms[m] = g;
                    if (m == 0) mp[m] = (g + 1) % N;
                    if (m == 0) q0.push_back((g << 8) | md[m]);
                    else        q1.push_back((g << 8) | md[m]);
                end else begin
                    mv[m] = 0;
                end
            end
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check(m == 0 ? "rr_out_valid" : "fp_out_valid", 32'(ov[m]), 32'(mv[m]));
            if (mv[m] != 0) begin
                check(m == 0 ? "rr_out_data" : "fp_out_data", 32'(od[m]), 32'(md[m]));
                check(m == 0 ? "rr_out_sel" : "fp_out_sel", 32'(os[m]), 32'(ms[m]));
            end
        end
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] held_sel;
        model_reset();
        in_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_valid", 32'(ov[0]), 32'd0);
        check("reset_sel", 32'(os[0]), 32'd0);

        // Single valid channel 2
        in_data[2*W +: W] = 8'hA5;
        in_valid = 4'b0100;
        step();
        check("ch2_data", 32'(od[0]), 32'hA5);
        check("ch2_sel", 32'(os[0]), 32'd2);

        // Asynchronous reset mid-cycle with a held beat
        out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_valid", 32'(ov[0]), 32'd0);
        check("async_data", 32'(od[0]), 32'd0);
        check("async_sel", 32'(os[0]), 32'd0);
        check("async_fp_valid", 32'(ov[1]), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;

        // Round-robin sweep
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'h10 + i);
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("sweep_sel", 32'(os[0]), 32'(k % N));
            check("sweep_data", 32'(od[0]), 32'(8'h10 + k % N));
        end

        // Backpressure for 3 cycles, then release
        held_sel = os[0];
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_ready", 32'(rdy[0]), 32'd0);
            check("stall_sel", 32'(os[0]), 32'(held_sel));
        end
        out_ready = 1'b1;
        step();
        check("release_valid", 32'(ov[0]), 32'd1);
        check("release_sel", 32'(os[0]), 32'd1);

        // Fixed priority starves channel 3 and ignores channel 0 when idle
        in_valid = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            step();
            check("fp_sel1", 32'(os[1]), 32'd1);
        end

        // Sparse request and wrap in round-robin
        sync_reset();
        in_valid = 4'b0100;
        step();
        check("wrap_sel2", 32'(os[0]), 32'd2);
        in_valid = 4'b0010;
        step();
        check("wrap_sel1", 32'(os[0]), 32'd1);
        in_valid = 4'b0011;
        step();
        check("wrap_sel0", 32'(os[0]), 32'd0);
        step();
        check("wrap_sel1b", 32'(os[0]), 32'd1);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            in_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain and confirm nothing is left over or lost
        in_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        check("rr_sb_left", 32'(q0.size()), 32'd0);
        check("fp_sb_left", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
